isp_ae_ctrl: RTL and testbench
==============================

# isp_ae_ctrl

Auto-exposure control loop stage that consumes the per-frame AE statistics (done pulse, pixel count, pixel sum) produced by the AE statistics block. It computes the frame mean luminance with a sequential divider and compares it against a runtime target with a dead-band. It then steps a clamped exposure value up or down and publishes it for the sensor/gain register writer. It runs entirely in the pixel clock domain and does nothing between frame-end pulses.

## Interface
Parameters:
- BITS, 8, raw pixel width; mean is saturated to BITS bits
- OUT_BITS, 32, width of in_cnt / in_sum; also the divider iteration count
- EXP_BITS, 16, exposure word width
- EXP_MIN, 4, lower clamp of exposure
- EXP_MAX, 1000, upper clamp of exposure
- EXP_INIT, 256, exposure value after reset
- STEP_SHIFT, 3, step size is exposure >> STEP_SHIFT, minimum 1

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  loop enable, sampled only when in_done is accepted
- in_done  in  1  one-cycle frame-statistics-valid pulse
- in_cnt  in  OUT_BITS  pixel count of the finished frame
- in_sum  in  OUT_BITS  pixel sum of the finished frame
- target  in  BITS  desired mean luminance
- tolerance  in  BITS  dead-band half-width
- out_exposure  out  EXP_BITS  current exposure; reset EXP_INIT
- out_valid  out  1  one-cycle pulse when out_exposure has been re-evaluated; reset 0
- out_mean  out  BITS  last computed mean, saturated; reset 0
- out_converged  out  1  last mean was inside the dead-band; reset 0
- busy  out  1  high in DIV and ADJ; reset 0

## Operation
- FSM states: IDLE, DIV, ADJ. Reset state is IDLE.
- IDLE: in_done & enable & (in_cnt != 0) latches in_cnt/in_sum and goes to DIV. in_done with enable=0 or in_cnt=0 is ignored: no state change, no out_valid, all outputs hold.
- DIV: restoring unsigned divide sum/cnt, one quotient bit per cycle, exactly OUT_BITS cycles, then goes to ADJ.
- ADJ: one cycle, then returns to IDLE.
  - Saturate the quotient to 2^BITS-1 and register it into out_mean.
  - Compute d = max(1, out_exposure >> STEP_SHIFT).
  - Compare in BITS+1-bit arithmetic, with no wrap on target±tolerance:
    - mean + tolerance < target: exposure = min(exp + d, EXP_MAX), converged = 0.
    - mean > target + tolerance: exposure = max(exp − d, EXP_MIN), converged = 0.
    - Otherwise: exposure unchanged, converged = 1.
  - The add/subtract is computed in EXP_BITS+1 bits before the clamp.
  - out_valid pulses in every ADJ, including the converged case.
- in_done arriving while busy (DIV or ADJ) is dropped. There is no queue and no error flag.
- target and tolerance are sampled combinationally in ADJ. enable has no effect once a frame has been accepted.

## Timing
- If in_done is accepted at edge k: DIV occupies edges k+1 .. k+OUT_BITS, ADJ is at edge k+OUT_BITS+1.
- out_exposure, out_mean, out_converged and out_valid update at edge k+OUT_BITS+2. out_valid is high for that single cycle.
- Latency for the default OUT_BITS=32 is therefore 34 cycles, far shorter than any vertical blank.
- busy goes high at edge k and low at edge k+OUT_BITS+2.
- Reset mid-operation: state returns to IDLE, out_exposure returns to EXP_INIT, and the partial divide is discarded.
- in_done coincident with the ADJ→IDLE edge is dropped, because the FSM is not yet in IDLE.

## Structure
- Shared ISP package holds:
  - FSM state encodings (IDLE/DIV/ADJ);
  - default EXP_* constants;
  - a saturate-to-BITS helper.
- Sub-module isp_div_seq: generic restoring divider with start/done handshake.
  - Parameter W.
  - Ports: start, dividend, divisor, quotient, done.
  - Reusable by the planned AWB gain block.

## Test plan
- Dark frame: cnt=1000, sum=50000, target=96, tol=8, exp=256 → out_mean=50, out_exposure=288, converged=0, out_valid exactly 34 cycles after in_done.
- Bright frame: cnt=1000, sum=200000, exp=256 → mean=200, out_exposure=224.
- In band: cnt=1000, sum=100000, target=96, tol=8 → mean=100, out_exposure unchanged at 256, converged=1, out_valid pulses.
- Clamps:
  - exp=990, dark frame → d=123, out_exposure=1000.
  - exp=5, bright frame → d=1, out_exposure=4, and stays 4 on a repeat.
  - sum=0xFFFFFFFF, cnt=1 → out_mean=255.
- Rejects:
  - cnt=0 → no out_valid, busy stays 0.
  - enable=0 → ignored.
  - Second in_done 10 cycles after the first → dropped, only one out_valid.
- Reset asserted at cycle 15 of DIV → busy=0, out_exposure=256, and the next in_done is processed normally.

Source files
------------

// File: rtl/isp_ae_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isp_ae_ctrl_pkg
// Description : Shared ISP auto-exposure definitions: FSM state encoding,
//               default exposure constants and a saturation helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package isp_ae_ctrl_pkg;

  // Auto-exposure control FSM states
  typedef enum logic [1:0] {
    AE_IDLE = 2'd0,
    AE_DIV  = 2'd1,
    AE_ADJ  = 2'd2
  } ae_state_e;

  // Default exposure loop constants
  localparam int AE_BITS_DEF       = 8;
  localparam int AE_OUT_BITS_DEF   = 32;
  localparam int AE_EXP_BITS_DEF   = 16;
  localparam int AE_EXP_MIN_DEF    = 4;
  localparam int AE_EXP_MAX_DEF    = 1000;
  localparam int AE_EXP_INIT_DEF   = 256;
  localparam int AE_STEP_SHIFT_DEF = 3;

  // Saturate an unsigned value to the largest number representable in
  // 'bits' bits (bits must be 1..63).
  function automatic logic [63:0] isp_sat_u(input logic [63:0] v,
                                            input int unsigned bits);
    logic [63:0] lim;
    lim = (64'd1 << bits) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isp_ae_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : isp_ae_ctrl_if
// Description : Per-frame AE statistics bus from the AE statistics block.
// Ports       : in_done - one-cycle frame-statistics-valid pulse
//               in_cnt  - pixel count of the finished frame
//               in_sum  - pixel sum of the finished frame
//               master  - statistics producer, slave - AE control loop
// Revision    : 1.0 - initial release
// ============================================================================
interface isp_ae_ctrl_if
  import isp_ae_ctrl_pkg::*;
#(
  parameter int OUT_BITS = AE_OUT_BITS_DEF
);
  logic                in_done;
  logic [OUT_BITS-1:0] in_cnt;
  logic [OUT_BITS-1:0] in_sum;

  modport master (output in_done, output in_cnt, output in_sum);
  modport slave  (input  in_done, input  in_cnt, input  in_sum);
endinterface
`default_nettype wire

// File: rtl/isp_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : isp_div_seq
// Description : Sequential restoring unsigned divider, one quotient bit per
//               clock, W iterations per divide. start is ignored while a
//               divide is running. done pulses for one cycle when quotient
//               is valid; quotient holds until the next start.
// Ports       : pclk, rst_n (async, active-low)
//               start    - load dividend/divisor and begin
//               dividend - W-bit numerator
//               divisor  - W-bit denominator (caller guarantees non-zero)
//               quotient - W-bit result
//               done     - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module isp_div_seq
  import isp_ae_ctrl_pkg::*;
#(
  parameter int W = AE_OUT_BITS_DEF
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    // Partial remainder shifted left with the next dividend bit; one bit
    // wider so the compare cannot overflow.
    rem_sh  = {rem_q, quo_q[W-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    if (run_q) begin
      if (rem_sh >= {1'b0, dsr_q}) begin
        rem_d = rem_sub[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      // Dividend is shifted out of quo_q as quotient bits shift in.
      quo_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      cnt_d = CW'(W);
      run_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: rtl/isp_ae_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : isp_ae_ctrl
// Description : Auto-exposure control loop. On each accepted frame-end
//               statistics pulse, divides pixel sum by pixel count to get
//               the mean luminance, compares it with target +/- tolerance
//               and steps the exposure by max(1, exposure >> STEP_SHIFT),
//               clamped to [EXP_MIN, EXP_MAX]. Latency is OUT_BITS+2 cycles.
// Ports       : pclk, rst_n (async, active-low)
//               enable        - loop enable, sampled when in_done accepted
//               target        - desired mean luminance
//               tolerance     - dead-band half-width
//               stats         - statistics bus (in_done/in_cnt/in_sum)
//               out_exposure  - current exposure value
//               out_valid     - one-cycle re-evaluation pulse
//               out_mean      - last mean, saturated to BITS
//               out_converged - last mean was inside the dead-band
//               busy          - frame being processed
// Revision    : 1.0 - initial release
// ============================================================================
module isp_ae_ctrl
  import isp_ae_ctrl_pkg::*;
#(
  parameter int BITS       = AE_BITS_DEF,
  parameter int OUT_BITS   = AE_OUT_BITS_DEF,
  parameter int EXP_BITS   = AE_EXP_BITS_DEF,
  parameter int EXP_MIN    = AE_EXP_MIN_DEF,
  parameter int EXP_MAX    = AE_EXP_MAX_DEF,
  parameter int EXP_INIT   = AE_EXP_INIT_DEF,
  parameter int STEP_SHIFT = AE_STEP_SHIFT_DEF
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [BITS-1:0]     target,
  input  logic [BITS-1:0]     tolerance,
  isp_ae_ctrl_if.slave        stats,
  output logic [EXP_BITS-1:0] out_exposure,
  output logic                out_valid,
  output logic [BITS-1:0]     out_mean,
  output logic                out_converged,
  output logic                busy
);

  ae_state_e             state_q, state_d;
  logic [EXP_BITS-1:0]   exposure_q, exposure_d;
  logic [BITS-1:0]       mean_q, mean_d;
  logic                  conv_q, conv_d;
  logic                  valid_q, valid_d;

  logic                  accept;
  logic [OUT_BITS-1:0]   div_quot;
  logic                  div_done;

  logic [BITS-1:0]       mean_sat;
  logic [BITS:0]         mean_plus_tol;
  logic [BITS:0]         target_plus_tol;
  logic                  too_dark;
  logic                  too_bright;
  logic [EXP_BITS-1:0]   step;
  logic [EXP_BITS:0]     exp_up;
  logic [EXP_BITS:0]     exp_dn;

  // Frames arriving outside IDLE are dropped; a zero count would make the
  // divide meaningless, so it is treated as no frame.
  assign accept = (state_q == AE_IDLE) && stats.in_done && enable &&
                  (stats.in_cnt != '0);

  isp_div_seq #(
    .W (OUT_BITS)
  ) u_div (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .start    (accept),
    .dividend (stats.in_sum),
    .divisor  (stats.in_cnt),
    .quotient (div_quot),
    .done     (div_done)
  );

  // Decision datapath, evaluated every cycle but only consumed in ADJ.
  always_comb begin
    mean_sat        = BITS'(isp_sat_u(64'(div_quot), BITS));
    // One extra bit so target/tolerance sums never wrap.
    mean_plus_tol   = {1'b0, mean_sat} + {1'b0, tolerance};
    target_plus_tol = {1'b0, target} + {1'b0, tolerance};
    too_dark        = mean_plus_tol < {1'b0, target};
    too_bright      = {1'b0, mean_sat} > target_plus_tol;
    step            = exposure_q >> STEP_SHIFT;
    if (step == '0) begin
      step = EXP_BITS'(1);
    end
    exp_up = {1'b0, exposure_q} + {1'b0, step};
    exp_dn = {1'b0, exposure_q} - {1'b0, step};
  end

  always_comb begin
    state_d    = state_q;
    exposure_d = exposure_q;
    mean_d     = mean_q;
    conv_d     = conv_q;
    valid_d    = 1'b0;
    case (state_q)
      AE_IDLE: begin
        if (accept) begin
          state_d = AE_DIV;
        end
      end
      AE_DIV: begin
        if (div_done) begin
          state_d = AE_ADJ;
        end
      end
      AE_ADJ: begin
        state_d = AE_IDLE;
        mean_d  = mean_sat;
        valid_d = 1'b1;
        if (too_dark) begin
          conv_d = 1'b0;
          if (exp_up > (EXP_BITS + 1)'(EXP_MAX)) begin
            exposure_d = EXP_BITS'(EXP_MAX);
          end else begin
            exposure_d = exp_up[EXP_BITS-1:0];
          end
        end else if (too_bright) begin
          conv_d = 1'b0;
          // MSB set means the subtraction went below zero.
          if (exp_dn[EXP_BITS] || (exp_dn < (EXP_BITS + 1)'(EXP_MIN))) begin
            exposure_d = EXP_BITS'(EXP_MIN);
          end else begin
            exposure_d = exp_dn[EXP_BITS-1:0];
          end
        end else begin
          conv_d = 1'b1;
        end
      end
      default: begin
        state_d = AE_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AE_IDLE;
      exposure_q <= EXP_BITS'(EXP_INIT);
      mean_q     <= '0;
      conv_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exposure_q <= exposure_d;
      mean_q     <= mean_d;
      conv_q     <= conv_d;
      valid_q    <= valid_d;
    end
  end

  assign out_exposure  = exposure_q;
  assign out_mean      = mean_q;
  assign out_converged = conv_q;
  assign out_valid     = valid_q;
  assign busy          = (state_q != AE_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_isp_ae_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_isp_ae_ctrl
// Description : Scoreboard testbench for isp_ae_ctrl. Stimulus pushes the
//               expected mean/exposure/converged/latency for each accepted
//               frame; a monitor pops and compares on every out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isp_ae_ctrl;

  typedef struct {
    logic [7:0]  mean;
    logic [15:0] expo;
    logic        conv;
    int          acc;
  } exp_t;

  logic        pclk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  target;
  logic [7:0]  tolerance;
  logic [15:0] out_exposure;
  logic        out_valid;
  logic [7:0]  out_mean;
  logic        out_converged;
  logic        busy;

  isp_ae_ctrl_if #(.OUT_BITS(32)) stats_if ();

  isp_ae_ctrl dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .enable        (enable),
    .target        (target),
    .tolerance     (tolerance),
    .stats         (stats_if),
    .out_exposure  (out_exposure),
    .out_valid     (out_valid),
    .out_mean      (out_mean),
    .out_converged (out_converged),
    .busy          (busy)
  );

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   valid_cnt = 0;
  int   cyc       = 0;
  logic busy_seen = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every out_valid against the scoreboard head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge pclk);
      if (busy) busy_seen = 1'b1;
      if (out_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("mean", 64'(out_mean), 64'(e.mean));
          chk("exposure", 64'(out_exposure), 64'(e.expo));
          chk("converged", 64'(out_converged), 64'(e.conv));
          chk("latency", 64'(cyc - e.acc), 64'd34);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] cnt, input logic [31:0] sum, input logic en,
                      input bit push, input logic [7:0] mean, input logic [15:0] expo,
                      input logic conv);
    exp_t e;
    @(posedge pclk);
    #1;
    stats_if.in_done = 1'b1;
    stats_if.in_cnt  = cnt;
    stats_if.in_sum  = sum;
    enable           = en;
    if (push) begin
      e.mean = mean; e.expo = expo; e.conv = conv; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge pclk);
    #1;
    stats_if.in_done = 1'b0;
    enable           = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge pclk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  localparam logic [31:0] DARK   = 32'd50000;
  localparam logic [31:0] BRIGHT = 32'd200000;
  localparam logic [31:0] INBAND = 32'd100000;

  initial begin
    int dark_tbl[13] = '{288, 324, 364, 409, 460, 517, 581, 653, 734, 825, 928, 1000, 1000};
    int e, d, n, vc0;

    rst_n = 1'b0;
    enable = 1'b1;
    target = 8'd96;
    tolerance = 8'd8;
    stats_if.in_done = 1'b0;
    stats_if.in_cnt  = '0;
    stats_if.in_sum  = '0;
    fork monitor(); join_none
    do_reset();
    @(negedge pclk);
    chk("rst_exposure", 64'(out_exposure), 64'd256);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mean", 64'(out_mean), 64'd0);
    chk("rst_conv", 64'(out_converged), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Dark frames from reset: steps up until clamped at EXP_MAX.
    for (int i = 0; i < 13; i++) begin
      send(32'd1000, DARK, 1'b1, 1'b1, 8'd50, 16'(dark_tbl[i]), 1'b0);
      if (i == 0) begin
        @(negedge pclk);
        chk("busy_in_div", 64'(busy), 64'd1);
      end
      drain();
    end

    // Bright frames from 1000 down to the EXP_MIN clamp and beyond.
    e = 1000;
    for (int i = 0; i < 50; i++) begin
      d = ((e >> 3) == 0) ? 1 : (e >> 3);
      n = e - d;
      if (n < 4) n = 4;
      send(32'd1000, BRIGHT, 1'b1, 1'b1, 8'd200, 16'(n), 1'b0);
      drain();
      e = n;
    end
    @(negedge pclk);
    chk("exp_floor", 64'(out_exposure), 64'd4);

    // Single bright frame from reset.
    do_reset();
    send(32'd1000, BRIGHT, 1'b1, 1'b1, 8'd200, 16'd224, 1'b0);
    drain();

    // In band: exposure unchanged, converged.
    do_reset();
    send(32'd1000, INBAND, 1'b1, 1'b1, 8'd100, 16'd256, 1'b1);
    drain();

    // Mean saturation.
    do_reset();
    send(32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'd255, 16'd224, 1'b0);
    drain();

    // cnt = 0 is ignored.
    busy_seen = 1'b0;
    vc0 = valid_cnt;
    send(32'd0, DARK, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
    repeat (40) @(posedge pclk);
    chk("cnt0_busy", 64'(busy_seen), 64'd0);
    chk("cnt0_valid", 64'(valid_cnt - vc0), 64'd0);

    // enable = 0 is ignored.
    busy_seen = 1'b0;
    vc0 = valid_cnt;
    send(32'd1000, DARK, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
    repeat (40) @(posedge pclk);
    chk("en0_busy", 64'(busy_seen), 64'd0);
    chk("en0_valid", 64'(valid_cnt - vc0), 64'd0);
    chk("en0_exposure", 64'(out_exposure), 64'd224);

    // Second in_done while busy is dropped (exposure 224 -> 252 on dark).
    vc0 = valid_cnt;
    send(32'd1000, DARK, 1'b1, 1'b1, 8'd50, 16'd252, 1'b0);
    repeat (8) @(posedge pclk);
    send(32'd1000, BRIGHT, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
    drain();
    repeat (40) @(posedge pclk);
    chk("double_valid_cnt", 64'(valid_cnt - vc0), 64'd1);

    // Reset in the middle of a divide.
    vc0 = valid_cnt;
    send(32'd1000, BRIGHT, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
    repeat (14) @(posedge pclk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_exposure", 64'(out_exposure), 64'd256);
    repeat (2) @(posedge pclk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge pclk);
    chk("midrst_no_valid", 64'(valid_cnt - vc0), 64'd0);
    send(32'd1000, DARK, 1'b1, 1'b1, 8'd50, 16'd288, 1'b0);
    drain();

    repeat (5) @(posedge pclk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
